// File: rtl/spi_pkg.sv
// Shared SPI peripheral definitions: FSM state encoding and the supported mode.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } spi_state_e;

  // Mode 0: sck idles low, sample on rising edge, launch on falling edge.
  localparam int unsigned SPI_MODE = 0;

endpackage

// File: rtl/spi_input_sync.sv
// Multi-flop synchronizer for one asynchronous input plus a registered
// edge detector; rise/fall are single-cycle pulses in the clk domain.
module spi_input_sync #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] chain;
  logic                   prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      chain <= {SYNC_STAGES{RST_VAL}};
      prev  <= RST_VAL;
    end else begin
      chain[0] <= din;
      for (int i = 1; i < SYNC_STAGES; i++) chain[i] <= chain[i-1];
      prev <= chain[SYNC_STAGES-1];
    end
  end

  assign q    = chain[SYNC_STAGES-1];
  assign rise = q & ~prev;
  assign fall = ~q & prev;

endmodule

// File: rtl/fast_spi_peripheral.sv
// SPI mode-0 peripheral running entirely in the clk domain: sck/cs/sdi are
// oversampled, framed by cs, and one RX_WIDTH-bit word is captured per frame.
module fast_spi_peripheral
  import spi_pkg::*;
#(
  parameter int TX_WIDTH    = 24,
  parameter int RX_WIDTH    = 24,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sck,
  input  logic                cs,
  input  logic                sdi,
  output logic                sdo,
  output logic                sdo_en,
  input  logic [TX_WIDTH-1:0] tx_data,
  output logic [RX_WIDTH-1:0] rx_data,
  output logic                rx_valid,
  output logic                frame_err,
  output logic                busy
);

  localparam int CNT_W = $clog2(RX_WIDTH + 1);

  logic sck_lvl_unused, sck_rise, sck_fall;
  logic cs_q, cs_rise, cs_fall;
  logic [SYNC_STAGES-1:0] sdi_chain;
  logic sdi_q;

  spi_input_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sck_sync (
    .clk(clk), .rst(rst), .din(sck),
    .q(sck_lvl_unused), .rise(sck_rise), .fall(sck_fall)
  );

  spi_input_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs_sync (
    .clk(clk), .rst(rst), .din(cs),
    .q(cs_q), .rise(cs_rise), .fall(cs_fall)
  );

  // sdi has the same depth as sck so the sampled bit lines up with sck_rise.
  always_ff @(posedge clk) begin
    if (rst) begin
      sdi_chain <= '0;
    end else begin
      sdi_chain[0] <= sdi;
      for (int i = 1; i < SYNC_STAGES; i++) sdi_chain[i] <= sdi_chain[i-1];
    end
  end
  assign sdi_q = sdi_chain[SYNC_STAGES-1];

  // The synchronizers come out of reset reading cs high, so a cs held low
  // through reset would look like a fresh falling edge. Ignore edges until
  // the chain has flushed, then require cs to be seen high before arming.
  logic [SYNC_STAGES:0] warm;
  logic                 armed;
  logic                 start;

  always_ff @(posedge clk) begin
    if (rst) begin
      warm  <= '0;
      armed <= 1'b0;
    end else begin
      warm <= {warm[SYNC_STAGES-1:0], 1'b1};
      if (!warm[SYNC_STAGES]) armed <= 1'b0;
      else if (cs_q)          armed <= 1'b1;
    end
  end
  assign start = cs_fall & armed & warm[SYNC_STAGES];

  spi_state_e          state;
  logic [CNT_W-1:0]    bit_cnt;
  logic [RX_WIDTH-1:0] rx_shift;
  logic [RX_WIDTH-1:0] rx_next;
  logic [TX_WIDTH-1:0] tx_shift;

  assign rx_next = {rx_shift[RX_WIDTH-2:0], sdi_q};

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      rx_shift  <= '0;
      tx_shift  <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            tx_shift <= tx_data;
            bit_cnt  <= '0;
            rx_shift <= '0;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          if (sck_rise) begin
            rx_shift <= rx_next;
            bit_cnt  <= bit_cnt + 1'b1;
            // Final bit wins over a coincident cs rise: word is delivered.
            if (bit_cnt == CNT_W'(RX_WIDTH - 1)) begin
              rx_data  <= rx_next;
              rx_valid <= 1'b1;
              state    <= cs_rise ? IDLE : HOLD;
            end else if (cs_rise) begin
              state     <= IDLE;
              frame_err <= 1'b1;
            end
          end else begin
            if (sck_fall) tx_shift <= tx_shift << 1;
            if (cs_rise) begin
              state     <= IDLE;
              frame_err <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (cs_rise) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign sdo    = (state == SHIFT) & tx_shift[TX_WIDTH-1];
  assign sdo_en = (state != IDLE) & ~cs_q;
  assign busy   = (state != IDLE);

endmodule

// File: tb/tb_fast_spi_peripheral.sv
// Directed bench for fast_spi_peripheral: acts as a mode-0 SPI controller
// with sck at 1/16 of clk and checks framing, data and error pulses.
module tb_fast_spi_peripheral;

  logic        clk = 1'b0;
  logic        rst, sck, cs, sdi;
  logic [23:0] tx_data;
  logic        sdo, sdo_en, rx_valid, frame_err, busy;
  logic [23:0] rx_data;

  int vectors = 0;
  int miscompares = 0;
  int rxv_cnt = 0;
  int fe_cnt = 0;

  fast_spi_peripheral #(.TX_WIDTH(24), .RX_WIDTH(24), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .sck(sck), .cs(cs), .sdi(sdi),
    .sdo(sdo), .sdo_en(sdo_en), .tx_data(tx_data), .rx_data(rx_data),
    .rx_valid(rx_valid), .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rx_valid === 1'b1)  rxv_cnt++;
    if (frame_err === 1'b1) fe_cnt++;
  end

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Controller: change sdi in the low phase, raise sck, capture sdo on the rise.
  task automatic shift_bits(input int n, input logic [63:0] mosi, output logic [63:0] miso);
    miso = '0;
    for (int i = 0; i < n; i++) begin
      sdi = mosi[n-1-i];
      wait_n(8);
      sck  = 1'b1;
      miso = {miso[62:0], sdo};
      wait_n(8);
      sck = 1'b0;
    end
  endtask

  task automatic cs_release();
    wait_n(8);
    cs = 1'b1;
    wait_n(8);
  endtask

  task automatic test_reset();
    rst = 1'b1; cs = 1'b1; sck = 1'b0; sdi = 1'b0; tx_data = '0;
    wait_n(3);
    vectors++; if (rx_data !== 24'h0) begin miscompares++; $display("FAIL reset_rx_data: got %h want %h", rx_data, 24'h0); end
    vectors++; if (rx_valid !== 1'b0) begin miscompares++; $display("FAIL reset_rx_valid: got %b want 0", rx_valid); end
    vectors++; if (frame_err !== 1'b0) begin miscompares++; $display("FAIL reset_frame_err: got %b want 0", frame_err); end
    vectors++; if (sdo !== 1'b0) begin miscompares++; $display("FAIL reset_sdo: got %b want 0", sdo); end
    vectors++; if (sdo_en !== 1'b0) begin miscompares++; $display("FAIL reset_sdo_en: got %b want 0", sdo_en); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
    rst = 1'b0;
    wait_n(6);
  endtask

  task automatic test_full_frame();
    logic [63:0] miso;
    int rv0, fe0;
    rv0 = rxv_cnt; fe0 = fe_cnt;
    tx_data = 24'hA5C3F0;
    cs = 1'b0;
    wait_n(8);
    vectors++; if (sdo !== 1'b1) begin miscompares++; $display("FAIL full_sdo_msb_pre: got %b want 1", sdo); end
    vectors++; if (sdo_en !== 1'b1 || busy !== 1'b1) begin miscompares++; $display("FAIL full_en_busy: got %b%b want 11", sdo_en, busy); end
    shift_bits(24, 64'h123456, miso);
    vectors++; if (rx_data !== 24'h123456) begin miscompares++; $display("FAIL full_rx_data: got %h want %h", rx_data, 24'h123456); end
    vectors++; if (miso[23:0] !== 24'hA5C3F0) begin miscompares++; $display("FAIL full_miso: got %h want %h", miso[23:0], 24'hA5C3F0); end
    vectors++; if (sdo !== 1'b0 || busy !== 1'b1) begin miscompares++; $display("FAIL full_hold: sdo %b busy %b want 0 1", sdo, busy); end
    cs_release();
    vectors++; if (rxv_cnt - rv0 !== 1) begin miscompares++; $display("FAIL full_rx_valid_pulses: got %0d want 1", rxv_cnt - rv0); end
    vectors++; if (fe_cnt - fe0 !== 0) begin miscompares++; $display("FAIL full_frame_err: got %0d want 0", fe_cnt - fe0); end
    vectors++; if (busy !== 1'b0 || sdo_en !== 1'b0) begin miscompares++; $display("FAIL full_idle: busy %b sdo_en %b want 0 0", busy, sdo_en); end
  endtask

  task automatic test_short_frame();
    logic [63:0] miso;
    int rv0, fe0;
    rv0 = rxv_cnt; fe0 = fe_cnt;
    tx_data = 24'hFFFFFF;
    cs = 1'b0;
    wait_n(8);
    shift_bits(10, 64'h3FF, miso);
    cs_release();
    vectors++; if (fe_cnt - fe0 !== 1) begin miscompares++; $display("FAIL short_frame_err: got %0d want 1", fe_cnt - fe0); end
    vectors++; if (rxv_cnt - rv0 !== 0) begin miscompares++; $display("FAIL short_rx_valid: got %0d want 0", rxv_cnt - rv0); end
    vectors++; if (rx_data !== 24'h123456) begin miscompares++; $display("FAIL short_rx_data: got %h want %h", rx_data, 24'h123456); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL short_busy: got %b want 0", busy); end
  endtask

  task automatic test_overclock();
    logic [63:0] miso;
    int rv0, fe0;
    rv0 = rxv_cnt; fe0 = fe_cnt;
    tx_data = 24'h0F0F0F;
    cs = 1'b0;
    wait_n(8);
    shift_bits(30, {34'h0, 24'hFFFFFF, 6'b000000}, miso);
    vectors++; if (rx_data !== 24'hFFFFFF) begin miscompares++; $display("FAIL over_rx_data: got %h want %h", rx_data, 24'hFFFFFF); end
    vectors++; if (miso[29:6] !== 24'h0F0F0F) begin miscompares++; $display("FAIL over_miso: got %h want %h", miso[29:6], 24'h0F0F0F); end
    vectors++; if (miso[5:0] !== 6'h00) begin miscompares++; $display("FAIL over_sdo_tail: got %h want 00", miso[5:0]); end
    cs_release();
    vectors++; if (fe_cnt - fe0 !== 0) begin miscompares++; $display("FAIL over_frame_err: got %0d want 0", fe_cnt - fe0); end
    vectors++; if (rxv_cnt - rv0 !== 1) begin miscompares++; $display("FAIL over_rx_valid: got %0d want 1", rxv_cnt - rv0); end
  endtask

  task automatic test_simultaneous();
    logic [63:0] miso;
    logic [23:0] w;
    int rv0, fe0;
    rv0 = rxv_cnt; fe0 = fe_cnt;
    w = 24'hABCDEF;
    tx_data = 24'h0;
    cs = 1'b0;
    wait_n(8);
    shift_bits(23, {41'h0, w[23:1]}, miso);
    sdi = w[0];
    wait_n(8);
    sck = 1'b1;
    cs  = 1'b1;
    wait_n(8);
    sck = 1'b0;
    wait_n(8);
    vectors++; if (rxv_cnt - rv0 !== 1) begin miscompares++; $display("FAIL simul_rx_valid: got %0d want 1", rxv_cnt - rv0); end
    vectors++; if (fe_cnt - fe0 !== 0) begin miscompares++; $display("FAIL simul_frame_err: got %0d want 0", fe_cnt - fe0); end
    vectors++; if (rx_data !== 24'hABCDEF) begin miscompares++; $display("FAIL simul_rx_data: got %h want %h", rx_data, 24'hABCDEF); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL simul_busy: got %b want 0", busy); end
  endtask

  task automatic test_reset_mid_frame();
    logic [63:0] miso;
    int rv0, fe0;
    rv0 = rxv_cnt; fe0 = fe_cnt;
    tx_data = 24'h123123;
    cs = 1'b0;
    wait_n(8);
    shift_bits(12, 64'hFFF, miso);
    rst = 1'b1;
    wait_n(3);
    rst = 1'b0;
    shift_bits(24, 64'hC0FFEE, miso);
    vectors++; if (rxv_cnt - rv0 !== 0) begin miscompares++; $display("FAIL rstmid_rx_valid: got %0d want 0", rxv_cnt - rv0); end
    vectors++; if (fe_cnt - fe0 !== 0) begin miscompares++; $display("FAIL rstmid_frame_err: got %0d want 0", fe_cnt - fe0); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rstmid_busy: got %b want 0", busy); end
    vectors++; if (rx_data !== 24'h0) begin miscompares++; $display("FAIL rstmid_rx_data: got %h want 000000", rx_data); end
    cs_release();
    cs = 1'b0;
    wait_n(8);
    shift_bits(24, 64'h5A5A5A, miso);
    cs_release();
    vectors++; if (rx_data !== 24'h5A5A5A) begin miscompares++; $display("FAIL rstmid_next_rx_data: got %h want %h", rx_data, 24'h5A5A5A); end
    vectors++; if (miso[23:0] !== 24'h123123) begin miscompares++; $display("FAIL rstmid_next_miso: got %h want %h", miso[23:0], 24'h123123); end
    vectors++; if (rxv_cnt - rv0 !== 1) begin miscompares++; $display("FAIL rstmid_next_rx_valid: got %0d want 1", rxv_cnt - rv0); end
  endtask

  task automatic test_back_to_back();
    logic [63:0] miso1, miso2;
    int rv0, fe0;
    rv0 = rxv_cnt; fe0 = fe_cnt;
    tx_data = 24'h111111;
    cs = 1'b0;
    wait_n(8);
    shift_bits(24, 64'h000001, miso1);
    wait_n(8);
    cs = 1'b1;
    tx_data = 24'h222222;
    wait_n(4);
    cs = 1'b0;
    vectors++; if (rx_data !== 24'h000001) begin miscompares++; $display("FAIL b2b_rx_data1: got %h want %h", rx_data, 24'h000001); end
    vectors++; if (rxv_cnt - rv0 !== 1) begin miscompares++; $display("FAIL b2b_rx_valid1: got %0d want 1", rxv_cnt - rv0); end
    wait_n(8);
    shift_bits(24, 64'h800000, miso2);
    cs_release();
    vectors++; if (rx_data !== 24'h800000) begin miscompares++; $display("FAIL b2b_rx_data2: got %h want %h", rx_data, 24'h800000); end
    vectors++; if (rxv_cnt - rv0 !== 2) begin miscompares++; $display("FAIL b2b_rx_valid2: got %0d want 2", rxv_cnt - rv0); end
    vectors++; if (miso1[23:0] !== 24'h111111) begin miscompares++; $display("FAIL b2b_miso1: got %h want %h", miso1[23:0], 24'h111111); end
    vectors++; if (miso2[23:0] !== 24'h222222) begin miscompares++; $display("FAIL b2b_miso2: got %h want %h", miso2[23:0], 24'h222222); end
    vectors++; if (fe_cnt - fe0 !== 0) begin miscompares++; $display("FAIL b2b_frame_err: got %0d want 0", fe_cnt - fe0); end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_full_frame();
    test_short_frame();
    test_overclock();
    test_simultaneous();
    test_reset_mid_frame();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
